// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the load/store path: datapath width, RV32I load/store
// funct3 encodings and the load/store unit FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_WB   = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store unit: byte-enable
// generation, store-data lane replication, load lane steering with sign/zero
// extension, and detection of requests that must not reach the bus.
// With LSU_MISALIGN_TRAP_EN defined, misaligned halfword/word accesses are
// also flagged for skipping; otherwise the offending low address bits are
// simply ignored by the lane logic.
// Ports:
//   i_store    1 = store, 0 = load
//   i_funct3   RV32I width/sign encoding
//   i_addr_lo  byte offset within the word (addr[1:0])
//   i_wdata    store data (rs2)
//   i_rdata    raw read data from the bus
//   o_be       byte enables
//   o_wdata    lane-replicated store data
//   o_ldata    steered and extended load data
//   o_skip     request must complete without a bus access
// -----------------------------------------------------------------------------
module lsu_align
    import riscv_pkg::*;
(
    input  logic            i_store,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_ldata,
    output logic            o_skip
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_illegal;

    always_comb begin
        w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            F3_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_ldata = {24'd0, w_byte};
            F3_H:    o_ldata = {{16{w_half[15]}}, w_half};
            F3_HU:   o_ldata = {16'd0, w_half};
            default: o_ldata = i_rdata;
        endcase

        // funct3[1:0] carries the access size for both loads and stores
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase

        w_illegal = i_store ? (i_funct3 > F3_W)
                            : ((i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11));
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misaligned;
    assign w_misaligned = ((i_funct3[1:0] == 2'b01) && i_addr_lo[0]) ||
                          ((i_funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00));
    assign o_skip = w_illegal || w_misaligned;
`else
    assign o_skip = w_illegal;
`endif

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Single-outstanding RV32I load/store unit. Accepts one request per handshake,
// issues a word-aligned bus transaction with byte enables, waits for the read
// response on loads and presents a one-cycle register write-back.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (adds fault/fault_addr and
// traps misaligned accesses instead of issuing them).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only when idle)
//   req_store, req_funct3    access type and width/sign encoding
//   req_addr, req_wdata      byte address and store data
//   req_rd                   load destination register
//   mem_valid/mem_ready      bus request handshake
//   mem_we, mem_be           bus write strobe and byte enables
//   mem_addr, mem_wdata      word address and lane-replicated store data
//   mem_rvalid, mem_rdata    bus read response
//   wb_we, wb_rd, wb_data    register-file write-back
//   busy                     high whenever not idle
//   fault, fault_addr        trap pulse and offending address (macro only)
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [RA_W-1:0] req_rd,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_we,
    output logic [RA_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            busy
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic            fault,
    output logic [XLEN-1:0] fault_addr
`endif
);

    import riscv_pkg::*;

    lsu_state_t      r_state;
    lsu_state_t      w_next;

    logic            r_store;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [RA_W-1:0] r_rd;
    logic [XLEN-1:0] r_wb_data;

    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata_rep;
    logic [XLEN-1:0] w_ldata;
    logic            w_skip;
    logic            w_issue;

    // Lane logic works on the latched request, so the bus and write-back
    // outputs depend only on registers, never directly on req_*.
    lsu_align u_align (
        .i_store   (r_store),
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (mem_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata_rep),
        .o_ldata   (w_ldata),
        .o_skip    (w_skip)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Request and load-result registers; reset so every output has a known
    // value straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_store   <= 1'b0;
            r_funct3  <= 3'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd      <= '0;
            r_wb_data <= '0;
        end else begin
            if ((r_state == ST_IDLE) && req_valid) begin
                r_store  <= req_store;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_rd     <= req_rd;
            end
            if ((r_state == ST_RESP) && mem_rvalid) r_wb_data <= w_ldata;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_next = ST_REQ;
            ST_REQ: begin
                // Skipped requests spend exactly this one cycle in REQ.
                // mem_rvalid is not looked at here, so a response in the
                // handshake cycle is ignored.
                if (w_skip)         w_next = ST_IDLE;
                else if (mem_ready) w_next = r_store ? ST_IDLE : ST_RESP;
            end
            ST_RESP: if (mem_rvalid) w_next = ST_WB;
            ST_WB:   w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_issue   = (r_state == ST_REQ) && !w_skip;
        req_ready = (r_state == ST_IDLE);
        busy      = (r_state != ST_IDLE);
        mem_valid = w_issue;
        mem_we    = w_issue && r_store;
        mem_be    = w_issue ? w_be : 4'd0;
        // x0 is never written, but the WB cycle still happens
        wb_we     = (r_state == ST_WB) && (r_rd != '0);
    end

    assign mem_addr  = {r_addr[XLEN-1:2], 2'b00};
    assign mem_wdata = w_wdata_rep;
    assign wb_rd     = r_rd;
    assign wb_data   = r_wb_data;

`ifdef LSU_MISALIGN_TRAP_EN
    assign fault      = (r_state == ST_REQ) && w_skip;
    assign fault_addr = r_addr;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        fault;
    logic [31:0] fault_addr;
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .RA_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .busy       (busy)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .fault      (fault),
        .fault_addr (fault_addr)
`endif
    );

    // Reference model, written from the ISA rules with plain arithmetic
    function automatic bit m_legal(input bit st, input logic [2:0] f3);
        int f = int'(f3);
        if (st) return (f <= 2);
        return (f == 0 || f == 1 || f == 2 || f == 4 || f == 5);
    endfunction

    function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] a);
        int sz = int'(f3) % 4;
        if (sz == 1) return (a % 2) != 0;
        if (sz == 2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = int'(f3) % 4;
        logic [31:0] v;
        if (sz == 0)      v = 32'd1 << (a % 4);
        else if (sz == 1) v = 32'd3 << (2 * ((a / 2) % 2));
        else              v = 32'd15;
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
        int sz = int'(f3) % 4;
        if (sz == 0) return (w % 256) * 32'h0101_0101;
        if (sz == 1) return (w % 65536) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] r);
        int f = int'(f3);
        logic [31:0] v;
        if (f == 0 || f == 4) begin
            v = (r >> (8 * (a % 4))) % 256;
            if (f == 0 && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (f == 1 || f == 5) begin
            v = (r >> (16 * ((a / 2) % 2))) % 65536;
            if (f == 1 && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = r;
        end
        return v;
    endfunction

    // Observations collected by run_access
    int          obs_first_mv, obs_hs, obs_done, obs_wb_cnt, obs_wb_cyc;
    int          obs_fault_cnt, obs_busy_err;
    logic [4:0]  obs_wb_rd;
    logic [31:0] obs_wb_data, obs_maddr, obs_mwdata, obs_fault_addr;
    logic [3:0]  obs_mbe;
    logic        obs_mwe;
    bit          obs_stable;

    // Drives one request and plays the bus; cycle 1 is the cycle after the
    // request handshake. rv_dly (>=1) is the rvalid distance after mem_ready.
    task automatic run_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] w, input logic [4:0] rd,
                              input logic [31:0] rdata, input int rdy_dly, input int rv_dly);
        int hs = 0;
        obs_first_mv = 0; obs_hs = 0; obs_done = 0; obs_wb_cnt = 0; obs_wb_cyc = 0;
        obs_fault_cnt = 0; obs_busy_err = 0; obs_wb_rd = '0; obs_wb_data = '0;
        obs_maddr = '0; obs_mwdata = '0; obs_fault_addr = '0; obs_mbe = '0;
        obs_mwe = 1'b0; obs_stable = 1'b1;
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a;
        req_wdata = w; req_rd = rd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_store = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        for (int c = 1; c <= 40; c++) begin
            mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (mem_valid) begin
                if (obs_first_mv == 0) begin
                    obs_first_mv = c; obs_maddr = mem_addr; obs_mbe = mem_be;
                    obs_mwdata = mem_wdata; obs_mwe = mem_we;
                end else if (mem_addr !== obs_maddr || mem_be !== obs_mbe ||
                             mem_wdata !== obs_mwdata || mem_we !== obs_mwe) begin
                    obs_stable = 1'b0;
                end
            end
            if (wb_we) begin
                obs_wb_cnt++; obs_wb_cyc = c; obs_wb_rd = wb_rd; obs_wb_data = wb_data;
            end
`ifdef LSU_MISALIGN_TRAP_EN
            if (fault) begin obs_fault_cnt++; obs_fault_addr = fault_addr; end
`endif
            if (busy !== ~req_ready) obs_busy_err++;
            if (req_ready) begin obs_done = c; break; end
            if (mem_valid && hs == 0 && (c - obs_first_mv) >= rdy_dly) begin
                mem_ready = 1'b1; hs = c;
                mem_rvalid = 1'b1; mem_rdata = ~rdata;   // must be ignored
            end else if (hs != 0 && !st && c == hs + rv_dly) begin
                mem_rvalid = 1'b1; mem_rdata = rdata;
            end
            @(posedge clk); #1;
        end
        obs_hs = hs;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        if (obs_done == 0) begin
            checks++; failures++;
            $display("FAIL access_timeout: req_ready not back within 40 cycles (st=%0b f3=%0d addr=%h)",
                     st, f3, a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid: got %b want 0", mem_valid); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_be !== 4'd0) begin failures++; $display("FAIL reset_mem_be: got %h want 0", mem_be); end
        checks++; if (mem_addr !== 32'd0) begin failures++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin failures++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL reset_wb_we: got %b want 0", wb_we); end
        checks++; if (wb_rd !== 5'd0) begin failures++; $display("FAIL reset_wb_rd: got %h want 0", wb_rd); end
        checks++; if (wb_data !== 32'd0) begin failures++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %b want 0", fault); end
        checks++; if (fault_addr !== 32'd0) begin failures++; $display("FAIL reset_fault_addr: got %h want 0", fault_addr); end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        run_access(1'b0, 3'b010, 32'h100, $urandom, 5'd5, 32'hDEADBEEF, 0, 2);
        checks++; if (obs_first_mv !== 1) begin failures++; $display("FAIL lw_mem_valid_cycle: got %0d want 1", obs_first_mv); end
        checks++; if (obs_maddr !== 32'h100) begin failures++; $display("FAIL lw_mem_addr: got %h want 00000100", obs_maddr); end
        checks++; if (obs_mbe !== 4'b1111) begin failures++; $display("FAIL lw_mem_be: got %b want 1111", obs_mbe); end
        checks++; if (obs_mwe !== 1'b0) begin failures++; $display("FAIL lw_mem_we: got %b want 0", obs_mwe); end
        checks++; if (obs_wb_cnt !== 1) begin failures++; $display("FAIL lw_wb_count: got %0d want 1", obs_wb_cnt); end
        checks++; if (obs_wb_cyc !== 4) begin failures++; $display("FAIL lw_wb_cycle: got %0d want 4", obs_wb_cyc); end
        checks++; if (obs_wb_rd !== 5'd5) begin failures++; $display("FAIL lw_wb_rd: got %0d want 5", obs_wb_rd); end
        checks++; if (obs_wb_data !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_wb_data: got %h want deadbeef", obs_wb_data); end
        checks++; if (obs_done !== 5) begin failures++; $display("FAIL lw_ready_cycle: got %0d want 5", obs_done); end
    endtask

    task automatic test_lb_lbu();
        run_access(1'b0, 3'b000, 32'h103, $urandom, 5'd9, 32'h8000_0000, 0, 1);
        checks++; if (obs_maddr !== 32'h100) begin failures++; $display("FAIL lb_mem_addr: got %h want 00000100", obs_maddr); end
        checks++; if (obs_mbe !== 4'b1000) begin failures++; $display("FAIL lb_mem_be: got %b want 1000", obs_mbe); end
        checks++; if (obs_wb_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_wb_data: got %h want ffffff80", obs_wb_data); end
        run_access(1'b0, 3'b100, 32'h103, $urandom, 5'd9, 32'h8000_0000, 1, 1);
        checks++; if (obs_maddr !== 32'h100) begin failures++; $display("FAIL lbu_mem_addr: got %h want 00000100", obs_maddr); end
        checks++; if (obs_wb_data !== 32'h0000_0080) begin failures++; $display("FAIL lbu_wb_data: got %h want 00000080", obs_wb_data); end
    endtask

    task automatic test_sh_stall();
        run_access(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd3, 32'h0, 3, 1);
        checks++; if (obs_maddr !== 32'h200) begin failures++; $display("FAIL sh_mem_addr: got %h want 00000200", obs_maddr); end
        checks++; if (obs_mbe !== 4'b1100) begin failures++; $display("FAIL sh_mem_be: got %b want 1100", obs_mbe); end
        checks++; if (obs_mwdata !== 32'hABCD_ABCD) begin failures++; $display("FAIL sh_mem_wdata: got %h want abcdabcd", obs_mwdata); end
        checks++; if (obs_mwe !== 1'b1) begin failures++; $display("FAIL sh_mem_we: got %b want 1", obs_mwe); end
        checks++; if (obs_stable !== 1'b1) begin failures++; $display("FAIL sh_stall_stable: got %b want 1", obs_stable); end
        checks++; if (obs_wb_cnt !== 0) begin failures++; $display("FAIL sh_no_wb: got %0d want 0", obs_wb_cnt); end
        checks++; if (obs_done !== 5) begin failures++; $display("FAIL sh_ready_cycle: got %0d want 5", obs_done); end
    endtask

    task automatic test_rd0();
        run_access(1'b0, 3'b010, 32'h480, $urandom, 5'd0, 32'h1111_2222, 0, 1);
        checks++; if (obs_first_mv !== 1) begin failures++; $display("FAIL rd0_bus_read: got cycle %0d want 1", obs_first_mv); end
        checks++; if (obs_wb_cnt !== 0) begin failures++; $display("FAIL rd0_wb_we: got %0d strobes want 0", obs_wb_cnt); end
        checks++; if (obs_done !== 4) begin failures++; $display("FAIL rd0_ready_cycle: got %0d want 4", obs_done); end
    endtask

    task automatic test_misalign();
        run_access(1'b0, 3'b001, 32'h301, $urandom, 5'd7, 32'h1234_F00D, 0, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (obs_first_mv !== 0) begin failures++; $display("FAIL mis_no_bus: got mem_valid at cycle %0d want none", obs_first_mv); end
        checks++; if (obs_fault_cnt !== 1) begin failures++; $display("FAIL mis_fault_pulse: got %0d want 1", obs_fault_cnt); end
        checks++; if (obs_fault_addr !== 32'h301) begin failures++; $display("FAIL mis_fault_addr: got %h want 00000301", obs_fault_addr); end
        checks++; if (obs_wb_cnt !== 0) begin failures++; $display("FAIL mis_no_wb: got %0d want 0", obs_wb_cnt); end
        checks++; if (obs_done !== 2) begin failures++; $display("FAIL mis_ready_cycle: got %0d want 2", obs_done); end
`else
        checks++; if (obs_mbe !== 4'b0011) begin failures++; $display("FAIL mis_mem_be: got %b want 0011", obs_mbe); end
        checks++; if (obs_maddr !== 32'h300) begin failures++; $display("FAIL mis_mem_addr: got %h want 00000300", obs_maddr); end
        checks++; if (obs_wb_data !== 32'hFFFF_F00D) begin failures++; $display("FAIL mis_wb_data: got %h want fffff00d", obs_wb_data); end
        checks++; if (obs_done !== 4) begin failures++; $display("FAIL mis_ready_cycle: got %0d want 4", obs_done); end
`endif
    endtask

    task automatic test_illegal();
        logic [2:0] codes [4] = '{3'b011, 3'b110, 3'b011, 3'b101};
        bit         sts   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_access(sts[i], codes[i], 32'h500, $urandom, 5'd4, $urandom, 0, 1);
            checks++; if (obs_first_mv !== 0) begin failures++; $display("FAIL illegal_no_bus[%0d]: got mem_valid at cycle %0d", i, obs_first_mv); end
            checks++; if (obs_wb_cnt !== 0) begin failures++; $display("FAIL illegal_no_wb[%0d]: got %0d want 0", i, obs_wb_cnt); end
            checks++; if (obs_done !== 2) begin failures++; $display("FAIL illegal_ready_cycle[%0d]: got %0d want 2", i, obs_done); end
`ifdef LSU_MISALIGN_TRAP_EN
            checks++; if (obs_fault_cnt !== 1) begin failures++; $display("FAIL illegal_fault[%0d]: got %0d want 1", i, obs_fault_cnt); end
`endif
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
        req_rd = 5'd6; req_wdata = $urandom;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_in_resp: busy got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL rstmid_mem_valid[%0d]: got %b want 0", i, mem_valid); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy[%0d]: got %b want 0", i, busy); end
            checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL rstmid_wb_we[%0d]: got %b want 0", i, wb_we); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            bit          st    = 1'($urandom);
            logic [2:0]  f3    = 3'($urandom);
            logic [31:0] a     = $urandom;
            logic [31:0] w     = $urandom;
            logic [4:0]  rd    = 5'($urandom);
            logic [31:0] rdat  = $urandom;
            int          rdy   = $urandom_range(0, 3);
            int          rv    = $urandom_range(1, 3);
            bit          skip  = !m_legal(st, f3) || (TRAP && m_misaligned(f3, a));
            bit          exp_wb = !skip && !st && (rd != 5'd0);
            int          exp_done;
            if (skip)    exp_done = 2;
            else if (st) exp_done = 2 + rdy;
            else         exp_done = 3 + rdy + rv;
            if (n % 3 == 0) f3 = 3'(f3 % 3);   // bias toward legal sizes
            if (n % 3 == 0) begin
                skip     = !m_legal(st, f3) || (TRAP && m_misaligned(f3, a));
                exp_wb   = !skip && !st && (rd != 5'd0);
                exp_done = skip ? 2 : (st ? 2 + rdy : 3 + rdy + rv);
            end
            run_access(st, f3, a, w, rd, rdat, rdy, rv);
            checks++; if (obs_done !== exp_done) begin failures++; $display("FAIL rnd_ready_cycle[%0d]: got %0d want %0d", n, obs_done, exp_done); end
            checks++; if (obs_busy_err !== 0) begin failures++; $display("FAIL rnd_busy[%0d]: %0d cycles busy==req_ready", n, obs_busy_err); end
            checks++; if (obs_wb_cnt !== int'(exp_wb)) begin failures++; $display("FAIL rnd_wb_count[%0d]: got %0d want %0d", n, obs_wb_cnt, exp_wb); end
            checks++; if ((obs_first_mv != 0) !== !skip) begin failures++; $display("FAIL rnd_bus_issue[%0d]: got first cycle %0d want issue=%0b", n, obs_first_mv, !skip); end
            if (!skip) begin
                checks++; if (obs_maddr !== {a[31:2], 2'b00}) begin failures++; $display("FAIL rnd_mem_addr[%0d]: got %h want %h", n, obs_maddr, a - (a % 4)); end
                checks++; if (obs_mbe !== m_be(f3, a)) begin failures++; $display("FAIL rnd_mem_be[%0d]: got %b want %b", n, obs_mbe, m_be(f3, a)); end
                checks++; if (obs_mwe !== st) begin failures++; $display("FAIL rnd_mem_we[%0d]: got %b want %b", n, obs_mwe, st); end
                checks++; if (obs_stable !== 1'b1) begin failures++; $display("FAIL rnd_stable[%0d]: bus fields changed during stall", n); end
                if (st) begin
                    checks++; if (obs_mwdata !== m_wdata(f3, w)) begin failures++; $display("FAIL rnd_mem_wdata[%0d]: got %h want %h", n, obs_mwdata, m_wdata(f3, w)); end
                end
            end
            if (exp_wb) begin
                checks++; if (obs_wb_rd !== rd) begin failures++; $display("FAIL rnd_wb_rd[%0d]: got %0d want %0d", n, obs_wb_rd, rd); end
                checks++; if (obs_wb_data !== m_load(f3, a, rdat)) begin failures++; $display("FAIL rnd_wb_data[%0d]: got %h want %h", n, obs_wb_data, m_load(f3, a, rdat)); end
                checks++; if (obs_wb_cyc !== exp_done - 1) begin failures++; $display("FAIL rnd_wb_cycle[%0d]: got %0d want %0d", n, obs_wb_cyc, exp_done - 1); end
            end
`ifdef LSU_MISALIGN_TRAP_EN
            checks++; if (obs_fault_cnt !== int'(skip)) begin failures++; $display("FAIL rnd_fault[%0d]: got %0d want %0d", n, obs_fault_cnt, skip); end
            if (skip) begin
                checks++; if (obs_fault_addr !== a) begin failures++; $display("FAIL rnd_fault_addr[%0d]: got %h want %h", n, obs_fault_addr, a); end
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh_stall();
        test_rd0();
        test_misalign();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
